// File: rtl/mmu_xlate.sv
// mmu_xlate: single-request translation core for the soft 68k MMU.
// A fully-associative TLB is searched first. On a miss, one single-level
// page descriptor is fetched over the walk port and cached round-robin.
module mmu_xlate #(
  parameter int VA_WIDTH    = 32,
  parameter int PA_WIDTH    = 32,
  parameter int PAGE_BITS   = 12,
  parameter int TLB_ENTRIES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [VA_WIDTH-1:0] req_va,
  input  logic [2:0]          req_fc,
  input  logic                req_rw_n,
  output logic                rsp_valid,
  output logic [PA_WIDTH-1:0] rsp_pa,
  output logic                rsp_hit,
  output logic                rsp_fault,
  output logic                walk_req,
  output logic [PA_WIDTH-1:0] walk_addr,
  input  logic                walk_ack,
  input  logic [31:0]         walk_data,
  input  logic                enable,
  input  logic [PA_WIDTH-1:0] root_ptr,
  input  logic                flush
);

  localparam int VPN_W = VA_WIDTH - PAGE_BITS;
  localparam int PFN_W = PA_WIDTH - PAGE_BITS;
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WALK   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]           state;
  logic [VA_WIDTH-1:0]  va_q;
  logic [2:0]           fc_q;
  logic                 rw_n_q;
  logic                 flush_seen;

  logic [TLB_ENTRIES-1:0] tlb_valid;
  logic [VPN_W-1:0]       tlb_vpn [TLB_ENTRIES];
  logic [PFN_W-1:0]       tlb_pfn [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] tlb_wp;
  logic [TLB_ENTRIES-1:0] tlb_s;
  logic [IDX_W-1:0]       rr_ptr;

  logic [VPN_W-1:0]     vpn;
  logic [PAGE_BITS-1:0] offset;
  logic                 bypass;
  logic [PA_WIDTH-1:0]  bypass_pa;
  logic                 hit;
  logic [PFN_W-1:0]     hit_pfn;
  logic                 hit_wp;
  logic                 hit_s;
  logic                 desc_page;
  logic                 desc_wp;
  logic                 desc_s;
  logic [PFN_W-1:0]     desc_pfn;
  logic                 fill_en;
  logic                 unused_desc;

  // Supervisor-only pages fault for user function codes; write-protected
  // pages fault for writes.
  function automatic logic perm_fault(input logic wp, input logic s,
                                      input logic [2:0] fc, input logic rw_n);
    return (s && !fc[2]) || (wp && !rw_n);
  endfunction

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign walk_req  = (state == ST_WALK);

  assign vpn       = va_q[VA_WIDTH-1:PAGE_BITS];
  assign offset    = va_q[PAGE_BITS-1:0];
  assign bypass    = !enable || (fc_q == 3'd7);
  assign bypass_pa = PA_WIDTH'(va_q);

  assign desc_page   = (walk_data[1:0] == 2'b01);
  assign desc_wp     = walk_data[2];
  assign desc_s      = walk_data[3];
  assign desc_pfn    = walk_data[PA_WIDTH-1:PAGE_BITS];
  assign unused_desc = ^walk_data;

  // A flush on the ack edge, or one seen earlier in this walk, drops the fill.
  assign fill_en = (state == ST_WALK) && walk_ack && desc_page && !flush && !flush_seen;

  // Associative search; fills only follow misses, so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_wp  = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_valid[i] && (tlb_vpn[i] == vpn)) begin
        hit     = 1'b1;
        hit_pfn = tlb_pfn[i];
        hit_wp  = tlb_wp[i];
        hit_s   = tlb_s[i];
      end
    end
  end

  // Request sequencing and the registered response/walk address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      va_q       <= '0;
      fc_q       <= '0;
      rw_n_q     <= 1'b0;
      flush_seen <= 1'b0;
      rsp_pa     <= '0;
      rsp_hit    <= 1'b0;
      rsp_fault  <= 1'b0;
      walk_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            va_q   <= req_va;
            fc_q   <= req_fc;
            rw_n_q <= req_rw_n;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          flush_seen <= 1'b0;
          if (bypass) begin
            rsp_pa    <= bypass_pa;
            rsp_hit   <= 1'b0;
            rsp_fault <= 1'b0;
            state     <= ST_RESP;
          end else if (hit) begin
            rsp_hit <= 1'b1;
            if (perm_fault(hit_wp, hit_s, fc_q, rw_n_q)) begin
              rsp_fault <= 1'b1;
              rsp_pa    <= '0;
            end else begin
              rsp_fault <= 1'b0;
              rsp_pa    <= {hit_pfn, offset};
            end
            state <= ST_RESP;
          end else begin
            walk_addr <= root_ptr + PA_WIDTH'({vpn, 2'b00});
            state     <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (flush) begin
            flush_seen <= 1'b1;
          end
          if (walk_ack) begin
            rsp_hit <= 1'b0;
            if (!desc_page || perm_fault(desc_wp, desc_s, fc_q, rw_n_q)) begin
              rsp_fault <= 1'b1;
              rsp_pa    <= '0;
            end else begin
              rsp_fault <= 1'b0;
              rsp_pa    <= {desc_pfn, offset};
            end
            state <= ST_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // TLB storage: flush clears all valid bits, fills go to the round-robin slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlb_valid <= '0;
      tlb_wp    <= '0;
      tlb_s     <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_vpn[i] <= '0;
        tlb_pfn[i] <= '0;
      end
    end else if (flush) begin
      tlb_valid <= '0;
    end else if (fill_en) begin
      tlb_valid[rr_ptr] <= 1'b1;
      tlb_vpn[rr_ptr]   <= vpn;
      tlb_pfn[rr_ptr]   <= desc_pfn;
      tlb_wp[rr_ptr]    <= desc_wp;
      tlb_s[rr_ptr]     <= desc_s;
      rr_ptr            <= rr_ptr + IDX_W'(1);
    end
  end

endmodule

// File: doc/mmu_xlate.md
# mmu_xlate

Parametrised translation core for the soft 68k MMU: it accepts one CPU access at a time, looks it up in a fully-associative TLB and, on a miss, fetches a single-level page descriptor over a memory walk port. It returns the physical address, a hit flag and a fault flag. It is the working successor of the MMU top-level stub and is instantiated beneath it. Root pointer, enable and flush come from the MMU register block.

## Interface
Parameters:
- VA_WIDTH, 32, virtual address width.
- PA_WIDTH, 32, physical address width; must be ≤ 32 and > PAGE_BITS.
- PAGE_BITS, 12, log2 page size; VPN = va[VA_WIDTH-1:PAGE_BITS].
- TLB_ENTRIES, 8, TLB depth; power of two, 2..64.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  core can accept a request.
- req_va  in  VA_WIDTH  virtual address.
- req_fc  in  3  68k function code.
- req_rw_n  in  1  1 = read, 0 = write.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_pa  out  PA_WIDTH  physical address.
- rsp_hit  out  1  response came from the TLB.
- rsp_fault  out  1  access faulted; rsp_pa is then 0.
- walk_req  out  1  descriptor fetch request, held until ack.
- walk_addr  out  PA_WIDTH  descriptor address.
- walk_ack  in  1  walk_data valid this cycle.
- walk_data  in  32  descriptor.
- enable  in  1  translation enable.
- root_ptr  in  PA_WIDTH  page table base, 4-byte aligned.
- flush  in  1  invalidate all TLB entries.

## Operation
- States: IDLE, LOOKUP, WALK, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid, latch va, fc and rw_n, then go to LOOKUP.
- LOOKUP, bypass case: if enable = 0 or fc = 7, rsp_pa = va, zero-extended or truncated to PA_WIDTH. No fault, rsp_hit = 0, TLB untouched. Go to RESP.
- LOOKUP, TLB hit: compare the VPN against all valid entries. On a hit, apply the permission check and go to RESP with rsp_hit = 1.
- LOOKUP, TLB miss: go to WALK.
- Descriptor format: bits [1:0] DT (01 = page, any other value is invalid); bit 2 WP; bit 3 S (supervisor only); bits [PA_WIDTH-1:PAGE_BITS] PFN.
- WALK: walk_addr = root_ptr + (VPN << 2), modulo 2^PA_WIDTH. walk_req is high for every WALK cycle.
- On walk_ack with DT ≠ 01: fault, no TLB fill.
- On walk_ack with DT = 01: fill the entry at the round-robin pointer, advance the pointer (wraps TLB_ENTRIES-1 → 0), then apply the permission check.
- Permission check, fault cases: S = 1 with fc[2] = 0 (user access); WP = 1 with rw_n = 0 (write).
- Permission check, pass: rsp_pa = {PFN, va[PAGE_BITS-1:0]}.
- A fill happens even if the permission check then faults.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. Response outputs hold their values until the next RESP.
- flush: clears every valid bit at the clock edge where it is sampled high.
  - It does not disturb an in-flight lookup or walk, and the response is still delivered.
  - A fill in the same cycle as flush is dropped (flush wins).
  - A fill completing after a flush that arrived during WALK is also dropped.
- There are no duplicate entries: a fill only happens after a miss, and requests are serialised.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_pa 0, rsp_hit 0, rsp_fault 0, walk_req 0, walk_addr 0, all valid bits 0, RR pointer 0.
- Request accepted at edge T → LOOKUP in cycle T+1 → RESP in cycle T+2 for a hit or bypass. req_ready returns at T+3.
- Miss: walk_req is first high in cycle T+2. If walk_ack arrives in cycle W, rsp_valid is high in cycle W+1.
- walk_ack outside WALK is ignored.
- Reset asserted mid-walk: walk_req drops asynchronously and no response is produced.
- enable and root_ptr are sampled in LOOKUP and WALK; changing them mid-walk applies from the next request only.

## Test plan
- Reset, then enable = 0, va 0x00123456, fc 5 → rsp_valid at T+2, pa 0x00123456, hit 0, fault 0.
- enable = 1, root 0x1000, va 0x00003ABC, fc 5, read → walk_addr 0x100C. Ack with desc 0x00055001 → pa 0x00055ABC, hit 0. Repeat the same request → hit 1, no walk_req.
- Descriptor 0x00066005 (WP) with a write → fault 1, pa 0. A following read to the same page → hit 1, pa 0x00066xxx, fault 0.
- Descriptor 0x00077009 (S) with fc 1 → fault. Same VPN with fc 5 → hit, no fault.
- Descriptor with DT = 00 → fault and no fill; the next access to the same page walks again.
- Fill TLB_ENTRIES + 1 distinct pages → the first page misses again (round-robin wrap). Assert flush during a walk → response delivered, but the next access to that page walks again.
